wb_writeback_regfile: RTL
=========================

// Module: wb_writeback_regfile
// PURPOSE
//   Write-back stage of the 5-stage RV32I core, directly downstream of the MEM/WB pipeline register.
//   Consumes the registered wb_* bundle and performs load-data alignment and sign/zero extension.
//   Selects ALU result vs load data and writes it into the 32-entry integer register file.
//   Serves the two ID-stage read ports with same-cycle WB->ID bypass, and counts retired instructions.
// PARAMETERS
//   XLEN    32   datapath / register width
//   NREGS   32   architectural registers; x0 hardwired to zero
//   CNT_W   64   width of retired-instruction counter
// PORTS
//   clk            in   1      core clock; all state updates on posedge
//   rstn           in   1      asynchronous, active-low reset
//   wb_valid       in   1      WB slot holds a real instruction (0 = bubble)
//   wb_mem_data    in   XLEN   raw aligned 32-bit word read from data RAM
//   wb_alu_o       in   XLEN   ALU result; bits[1:0] give the load byte offset
//   wb_rd          in   5      destination register index
//   wb_mem2reg     in   1      1: write load data, 0: write ALU result
//   wb_regs_write  in   1      instruction writes rd
//   wb_func3_code  in   3      load width/sign (funct3)
//   id_rs1         in   5      ID read port 1 index
//   id_rs2         in   5      ID read port 2 index
//   id_rs1_data    out  XLEN   read data port 1 (combinational)
//   id_rs2_data    out  XLEN   read data port 2 (combinational)
//   wb_wdata       out  XLEN   value being written back (to EX forwarding mux)
//   wb_we          out  1      effective write enable (to hazard unit)
//   instret        out  CNT_W  retired-instruction count
// BEHAVIOUR
//   Load extract (little-endian), off = wb_alu_o[1:0]:
//     000 LB : sign-extend byte[off];  100 LBU: zero-extend byte[off]
//     001 LH : sign-extend half[off[1]]; 101 LHU: zero-extend half[off[1]]; off[0] ignored
//     010 LW and any other code: full word, offset ignored
//   wb_wdata = wb_mem2reg ? extracted_load : wb_alu_o (pure combinational, no added latency).
//   wb_we = wb_valid & wb_regs_write & (wb_rd != 0); x0 is never written.
//   Regfile: regs[wb_rd] <= wb_wdata on posedge when wb_we; one write per cycle.
//   Read ports (each independently): rs==0 -> 0; else rs==wb_rd && wb_we -> wb_wdata (bypass);
//     else regs[rs]. Both ports reading the written register in the same cycle both bypass.
//   instret: +1 on posedge when wb_valid (bubbles not counted, regardless of regs_write);
//     wraps modulo 2^CNT_W, no saturation.
//   Reset (async, rstn=0): all regs[1..31] <= 0, instret <= 0 immediately; writes suppressed
//     while rstn=0; after release, reads return 0 until written. Reset asserted mid-stream
//     discards the in-flight WB write of that cycle.
//   Combinational outputs (id_rs*_data, wb_wdata, wb_we) follow inputs; with zeroed MEM/WB
//     bundle after reset they read 0.
//   Latency: write visible to ID same cycle via bypass, from array the following cycle.
// TESTING
//   1. Reset then read all x0..x31 -> all 0; instret=0.
//   2. wb_valid=1, regs_write=1, mem2reg=0, rd=5, alu_o=0xDEADBEEF; id_rs1=5 same cycle
//      -> id_rs1_data=0xDEADBEEF (bypass); next cycle still 0xDEADBEEF from array.
//   3. mem_data=0x8001_7F80, mem2reg=1: LB off=0 -> 0xFFFFFF80; LBU off=0 -> 0x00000080;
//      LB off=1 -> 0x0000007F; LH off=2 -> 0xFFFF8001; LHU off=2 -> 0x00008001; LW -> 0x80017F80.
//   4. rd=0, regs_write=1, alu_o=0x1234 -> wb_we=0, x0 reads 0; also regs_write=1 with
//      wb_valid=0 -> no write, instret unchanged.
//   5. 10 valid + 3 bubble cycles -> instret=10; preload instret near 2^CNT_W-1 (CNT_W=8 build)
//      -> wraps 255->0.
//   6. Write x7=0x55 then assert rstn=0 mid-cycle with a pending write to x8 -> x7=x8=0 after reset.

Source files
------------

// File: rtl/wb_writeback_regfile.sv
// Write-back stage of the RV32I pipeline: load alignment/extension, result select,
// 32-entry integer register file with WB->ID bypass, and retired-instruction counter.
module wb_writeback_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wb_valid,
   input  logic [XLEN-1:0]  wb_mem_data,
   input  logic [XLEN-1:0]  wb_alu_o,
   input  logic [4:0]       wb_rd,
   input  logic             wb_mem2reg,
   input  logic             wb_regs_write,
   input  logic [2:0]       wb_func3_code,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   output logic [XLEN-1:0]  id_rs1_data,
   output logic [XLEN-1:0]  id_rs2_data,
   output logic [XLEN-1:0]  wb_wdata,
   output logic             wb_we,
   output logic [CNT_W-1:0] instret
);

   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] load_data;
   logic [1:0]      off;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;

   assign off = wb_alu_o[1:0];

   always_comb begin
      ld_byte = 8'h00;
      ld_half = 16'h0000;
      case (off)
         2'd0:    ld_byte = wb_mem_data[7:0];
         2'd1:    ld_byte = wb_mem_data[15:8];
         2'd2:    ld_byte = wb_mem_data[23:16];
         default: ld_byte = wb_mem_data[31:24];
      endcase
      // Halfword selection ignores off[0]; misaligned halves are not split.
      ld_half = off[1] ? wb_mem_data[31:16] : wb_mem_data[15:0];
   end

   always_comb begin
      load_data = wb_mem_data;
      case (wb_func3_code)
         3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
         3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
         default: load_data = wb_mem_data;
      endcase
   end

   assign wb_wdata = wb_mem2reg ? load_data : wb_alu_o;
   assign wb_we    = wb_valid & wb_regs_write & (wb_rd != 5'd0);

   // x0 is held at zero because wb_we never fires for rd==0.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_we) begin
         regs[wb_rd] <= wb_wdata;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)         instret <= '0;
      else if (wb_valid) instret <= instret + CNT_W'(1);
   end

   // Each read port independently bypasses the in-flight write.
   always_comb begin
      id_rs1_data = regs[id_rs1];
      if (id_rs1 == 5'd0)                 id_rs1_data = '0;
      else if (wb_we && id_rs1 == wb_rd)  id_rs1_data = wb_wdata;
   end

   always_comb begin
      id_rs2_data = regs[id_rs2];
      if (id_rs2 == 5'd0)                 id_rs2_data = '0;
      else if (wb_we && id_rs2 == wb_rd)  id_rs2_data = wb_wdata;
   end

endmodule
